// File: rtl/mem_reader_if.sv
// Bundle of the mem_reader command, memory-read and output-stream signals.
//   start/base_addr/length : burst command (sampled only while the reader is idle)
//   busy/done              : burst status
//   mem_rd/mem_addr        : read issue towards a registered-address memory
//   mem_dout               : memory read data, valid the cycle after issue
//   m_valid/m_ready/m_data : output word stream
// master = the reader itself, slave = the environment (command source, memory, consumer).
interface mem_reader_if #(
    parameter int unsigned addr_width = 6,
    parameter int unsigned bus_width  = 14
);
    logic                  start;
    logic [addr_width-1:0] base_addr;
    logic [addr_width:0]   length;
    logic                  busy;
    logic                  done;
    logic                  mem_rd;
    logic [addr_width-1:0] mem_addr;
    logic [bus_width-1:0]  mem_dout;
    logic                  m_valid;
    logic                  m_ready;
    logic [bus_width-1:0]  m_data;

    modport master (
        input  start, base_addr, length, mem_dout, m_ready,
        output busy, done, mem_rd, mem_addr, m_valid, m_data
    );

    modport slave (
        output start, base_addr, length, mem_dout, m_ready,
        input  busy, done, mem_rd, mem_addr, m_valid, m_data
    );
endinterface

// File: rtl/mem_reader.sv
// Burst reader: on start, reads `length` consecutive words (wrapping) from a
// registered-address memory and streams them out through a 2-entry FIFO.
//   clk    : clock, rising edge
//   rstn   : synchronous active-low reset
//   bus_io : mem_reader_if master modport (command, memory read port, output stream)
module mem_reader #(
    parameter int unsigned addr_width = 6,
    parameter int unsigned bus_width  = 14
) (
    input logic           clk,
    input logic           rstn,
    mem_reader_if.master  bus_io
);
    typedef enum logic [1:0] {StIdle, StRead, StDrain} state_e;

    state_e                state_q, state_d;
    logic [addr_width:0]   rem_q, rem_d;      // reads still to issue
    logic [addr_width-1:0] addr_q, addr_d;
    logic                  inflight_q, inflight_d;
    logic [bus_width-1:0]  fifo_q [2];
    logic                  wptr_q, wptr_d;
    logic                  rptr_q, rptr_d;
    logic [1:0]            cnt_q, cnt_d;

    logic       accept;
    logic       pop;
    logic       issue;
    logic       empty_idle;
    logic [2:0] occ;

    assign accept     = (state_q == StIdle) && bus_io.start;
    assign pop        = (cnt_q != 2'd0) && bus_io.m_ready;
    // Words that will need a FIFO slot: buffered plus the one read in flight.
    assign occ        = {1'b0, cnt_q} + {2'b00, inflight_q};
    // A pop in the same cycle frees the slot that the new read will land in.
    assign issue      = (state_q == StRead) && ((occ <= 3'd1) || ((occ == 3'd2) && pop));
    assign empty_idle = !inflight_q && (cnt_q == 2'd0);

    // State register
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (bus_io.start) begin
                    state_d = (bus_io.length == '0) ? StDrain : StRead;
                end
            end
            StRead: begin
                if (issue && (rem_q == {{addr_width{1'b0}}, 1'b1})) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (empty_idle) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs
    always_comb begin
        bus_io.busy     = (state_q != StIdle);
        bus_io.done     = (state_q == StDrain) && empty_idle;
        bus_io.mem_rd   = issue;
        bus_io.mem_addr = addr_q;
        bus_io.m_valid  = (cnt_q != 2'd0);
        bus_io.m_data   = fifo_q[rptr_q];
    end

    // Datapath next-state
    always_comb begin
        addr_d     = addr_q;
        rem_d      = rem_q;
        inflight_d = issue;
        wptr_d     = inflight_q ? ~wptr_q : wptr_q;
        rptr_d     = pop ? ~rptr_q : rptr_q;
        cnt_d      = cnt_q + {1'b0, inflight_q} - {1'b0, pop};
        if (accept) begin
            addr_d = bus_io.base_addr;
            rem_d  = bus_io.length;
        end else if (issue) begin
            addr_d = addr_q + 1'b1;
            rem_d  = rem_q - 1'b1;
        end
    end

    // Datapath registers; capture lands one cycle after issue
    always_ff @(posedge clk) begin
        if (!rstn) begin
            addr_q     <= '0;
            rem_q      <= '0;
            inflight_q <= 1'b0;
            wptr_q     <= 1'b0;
            rptr_q     <= 1'b0;
            cnt_q      <= 2'd0;
            fifo_q[0]  <= '0;
            fifo_q[1]  <= '0;
        end else begin
            addr_q     <= addr_d;
            rem_q      <= rem_d;
            inflight_q <= inflight_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            cnt_q      <= cnt_d;
            if (inflight_q) begin
                fifo_q[wptr_q] <= bus_io.mem_dout;
            end
        end
    end
endmodule

// File: tb/tb_mem_reader.sv
// Self-checking bench for mem_reader: directed bursts plus random ones, each
// checked against a queue of expected addresses/words built from the memory image.
module tb_mem_reader;
    localparam int unsigned AW = 6;
    localparam int unsigned BW = 14;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    mem_reader_if #(.addr_width(AW), .bus_width(BW)) bus ();

    mem_reader #(.addr_width(AW), .bus_width(BW)) dut (
        .clk    (clk),
        .rstn   (rstn),
        .bus_io (bus)
    );

    logic [BW-1:0] mem [64];

    // Registered-address memory model
    always @(posedge clk) begin
        if (bus.mem_rd) bus.mem_dout <= mem[bus.mem_addr];
    end

    int passed = 0;
    int total  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // mode: 0 = ready always high, 1 = ready pattern 1,0,0,..., 2 = random ready
    task automatic burst(input int base, input int len, input int mode, input bit restart,
                         input int abort_after);
        int exp_q[$];
        int addr_exp[$];
        int issued, popped, first_rd, first_v, first_pop, last_pop, done_cyc;
        bit hold_valid;
        logic [BW-1:0] held;
        for (int i = 0; i < len; i++) begin
            addr_exp.push_back((base + i) % 64);
            exp_q.push_back(int'(mem[(base + i) % 64]));
        end
        @(posedge clk); #1;
        bus.start     = 1'b1;
        bus.base_addr = base[AW-1:0];
        bus.length    = len[AW:0];
        bus.m_ready   = 1'b1;
        @(negedge clk);
        check("idle_before_start", bus.busy, 0);
        issued = 0; popped = 0; first_rd = -1; first_v = -1;
        first_pop = -1; last_pop = -1; done_cyc = -1;
        hold_valid = 1'b0; held = '0;
        for (int k = 1; k <= 300 && done_cyc < 0; k++) begin
            @(posedge clk); #1;
            bus.start     = restart && (k == 2 || k == 4);
            bus.base_addr = 6'd7;
            bus.length    = 7'd3;
            case (mode)
                0:       bus.m_ready = 1'b1;
                1:       bus.m_ready = ((k - 1) % 3 == 0);
                default: bus.m_ready = 1'($urandom_range(0, 1));
            endcase
            @(negedge clk);
            if (hold_valid) begin
                check("hold_valid", bus.m_valid, 1);
                check("hold_data", bus.m_data, held);
            end
            if (k == 1) check("busy_after_start", bus.busy, 1);
            if (bus.mem_rd) begin
                if (first_rd < 0) first_rd = k;
                if (issued < len) check("rd_addr", bus.mem_addr, addr_exp[issued]);
                issued++;
            end
            if (bus.m_valid && first_v < 0) first_v = k;
            if (bus.m_valid && bus.m_ready) begin
                if (exp_q.size() > 0) check("data", bus.m_data, exp_q.pop_front());
                else check("extra_word", popped + 1, len);
                popped++;
                if (first_pop < 0) first_pop = k;
                last_pop = k;
            end
            hold_valid = bus.m_valid && !bus.m_ready;
            held       = bus.m_data;
            check("outstanding_le2", (issued - popped) <= 2, 1);
            if (abort_after > 0 && popped == abort_after) begin
                bus.start = 1'b0;
                return;
            end
            if (bus.done) done_cyc = k;
        end
        check("done_seen", done_cyc > 0, 1);
        check("issued", issued, len);
        check("delivered", popped, len);
        if (len == 0) begin
            check("done_lat_len0", done_cyc, 1);
            check("no_rd_len0", first_rd, -1);
            check("no_valid_len0", first_v, -1);
        end else begin
            check("first_rd_lat", first_rd, 1);
            check("first_valid_lat", first_v, 3);
            check("done_after_last", done_cyc, last_pop + 1);
            if (mode == 0) check("throughput", last_pop - first_pop, len - 1);
        end
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            check("post_done", bus.done, 0);
            check("post_busy", bus.busy, 0);
            @(posedge clk); #1;
        end
    endtask

    initial begin
        rstn          = 1'b0;
        bus.start     = 1'b0;
        bus.base_addr = '0;
        bus.length    = '0;
        bus.m_ready   = 1'b0;
        for (int i = 0; i < 64; i++) mem[i] = BW'($urandom);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_mem_rd", bus.mem_rd, 0);
        check("rst_m_valid", bus.m_valid, 0);
        check("rst_mem_addr", bus.mem_addr, 0);
        check("rst_m_data", bus.m_data, 0);
        @(posedge clk); #1;
        rstn = 1'b1;

        burst(5, 4, 0, 1'b0, 0);
        burst(62, 4, 0, 1'b0, 0);
        burst(10, 8, 1, 1'b0, 0);
        burst(33, 0, 0, 1'b0, 0);
        burst(40, 6, 0, 1'b1, 0);

        // Abort mid-burst after two words
        burst(20, 6, 0, 1'b0, 2);
        @(posedge clk); #1;
        rstn = 1'b0;
        @(negedge clk);
        check("pre_reset_done", bus.done, 0);
        @(posedge clk); #1;
        rstn = 1'b1;
        @(negedge clk);
        check("abort_busy", bus.busy, 0);
        check("abort_done", bus.done, 0);
        check("abort_mem_rd", bus.mem_rd, 0);
        check("abort_m_valid", bus.m_valid, 0);
        check("abort_mem_addr", bus.mem_addr, 0);
        check("abort_m_data", bus.m_data, 0);
        for (int j = 0; j < 3; j++) begin
            @(posedge clk); #1;
            @(negedge clk);
            check("abort_no_done", bus.done, 0);
        end
        burst(0, 2, 0, 1'b0, 0);

        for (int r = 0; r < 6; r++) begin
            burst(int'($urandom_range(0, 63)), int'($urandom_range(0, 10)), 2, 1'b0, 0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
